timer_core_param: RTL and testbench
===================================

// Module: timer_core_param
// PURPOSE
//  Parametrised mm:ss timer core with count-up/count-down mode, pause/resume, lap capture and expiry.
//  Sits between the button debouncer and the 7-seg scan driver and replaces the fixed 50 MHz stopwatch counter.
//  All control inputs are debounced single-cycle pulses or levels.
//  Outputs are binary and BCD time plus status, for the display mux and the LED.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency
//  TICK_HZ  1           count rate; TICK_DIV = CLK_HZ/TICK_HZ (localparam, must be >=2)
//  MIN_MAX  59          largest minute value (1..99)
//  MW       7           minute field width; must hold MIN_MAX
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  power_en     in   1   level; 0 forces OFF
//  start_stop   in   1   pulse; toggles run/pause
//  clear        in   1   pulse; zero the count (ignored in RUN)
//  mode_down    in   1   level; 1 = countdown; sampled only outside RUN
//  set_mode     in   1   level; 1 = time-set mode
//  inc_min      in   1   pulse; +1 minute in SET
//  inc_sec      in   1   pulse; +1 second in SET
//  lap          in   1   pulse; capture current time (RUN only)
//  min_o        out  MW  minutes, binary
//  sec_o        out  6   seconds, binary
//  min_bcd      out  8   minutes, BCD {tens,units}
//  sec_bcd      out  8   seconds, BCD
//  lap_min      out  MW  captured minutes
//  lap_sec      out  6   captured seconds
//  lap_valid    out  1   high after the first capture; cleared by clear or power-off
//  running_o    out  1   1 in RUN
//  wrap_o       out  1   1-cycle pulse on up-count wrap MIN_MAX:59 -> 00:00
//  expired_o    out  1   1-cycle pulse on entering DONE
//  led_state    out  1   1 in RUN; toggles on each tick in DONE; else 0
// BEHAVIOUR
//  Reset
//   - Every output is 0 and the state is OFF on the first edge with rst=1.
//   - rst overrides every other input, including mid-RUN.
//  States: OFF, IDLE, RUN, PAUSE, SET, DONE
//   - OFF: go to IDLE when power_en=1. From any state, power_en=0 goes to OFF, zeroes count and lap, clears lap_valid.
//   - IDLE: start_stop goes to RUN; if mode_down=1 and the count is 00:00, start_stop is ignored. set_mode=1 goes to SET.
//   - RUN: start_stop goes to PAUSE. Countdown reaching 00:00 goes to DONE.
//   - PAUSE: start_stop goes to RUN. set_mode=1 goes to SET. clear goes to IDLE with 00:00.
//   - SET: set_mode=0 goes to IDLE, keeping the value. inc_sec wraps 59->0 with no carry; inc_min wraps MIN_MAX->0.
//   - DONE: holds 00:00. start_stop or clear goes to IDLE.
//  Priority (same cycle): power_en=0 > set_mode > start_stop > clear.
//  Prescaler
//   - Counts 0..TICK_DIV-1 in RUN and DONE. tick = terminal count.
//   - Frozen in PAUSE, so the sub-second fraction is kept. Zeroed in OFF/IDLE/SET.
//   - First tick comes TICK_DIV cycles after entering RUN from IDLE.
//  Count update
//   - Registered on the tick edge; visible on the next cycle.
//   - Up: sec 59 -> 0 carries into min; MIN_MAX:59 -> 00:00 pulses wrap_o and keeps running.
//   - Down: sec 0 -> 59 borrows; 00:01 -> 00:00 enters DONE and pulses expired_o the same edge.
//  Inputs outside their state
//   - inc_* are ignored outside SET. lap is ignored outside RUN.
//   - mode_down changes during RUN take effect at the next entry to RUN.
//  Lap
//   - lap coinciding with tick captures the pre-tick value.
//   - lap with start_stop in the same cycle: both are honoured.
//  BCD
//   - Combinational from min_o/sec_o (tens = v/10, units = v%10), no added latency.
// STRUCTURE
//  - timer_pkg: state enum (OFF, IDLE, RUN, PAUSE, SET, DONE), SEC_MAX=59.
//  - Sub-module tick_gen (prescaler with run/hold/clear controls, tick output).
//  - Top holds the FSM, mm:ss counter, lap registers and BCD conversion.
// TESTING (CLK_HZ=10, TICK_HZ=1 -> TICK_DIV=10, MIN_MAX=59)
//  1. rst for 2 cycles mid-RUN at 00:05 -> all outputs 0, state OFF; power_en=1 -> IDLE, 00:00.
//  2. Up, start_stop, 650 cycles -> 01:05, min_bcd=8'h01, sec_bcd=8'h05.
//     Preload 59:58 in SET, run 20 cycles -> 00:00 with a single wrap_o pulse.
//  3. Pause after 35 cycles (03), hold 100 cycles -> stays 03.
//     Resume -> 04 arrives after 5 more cycles (fraction kept).
//  4. SET: 2x inc_min, 3x inc_sec -> 02:03. inc_sec x57 -> wraps to 02:00, no carry.
//     Exit, mode_down=1, run 1200 cycles -> 00:00, expired_o one pulse, DONE, led toggles per tick.
//  5. lap on a tick cycle at 00:07 -> lap_sec=7, sec_o=8, lap_valid=1.
//     clear while RUN is ignored; after pause, clear -> 00:00 and lap_valid=0.
//  6. mode_down=1 at 00:00 with start_stop -> stays IDLE.
//     power_en=0 during RUN -> OFF, all counts 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the mm:ss timer core.
//   state_t : timer operating states
//   SEC_MAX : largest seconds value before carry/borrow
package timer_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_SET,
        ST_DONE
    } state_t;

    localparam int SEC_MAX = 59;

endpackage

// File: rtl/timer_core_param_if.sv
// Control and status bundle between the timer core and its neighbours
// (button debouncer on the control side, display mux / LED on the status side).
//   Controls : power_en, start_stop, clear, mode_down, set_mode, inc_min, inc_sec, lap
//   Status   : min_o, sec_o, min_bcd, sec_bcd, lap_min, lap_sec, lap_valid,
//              running_o, wrap_o, expired_o, led_state
//   master   : drives controls, observes status
//   slave    : the timer core
interface timer_core_param_if #(
    parameter int MW = 7
);
    logic          power_en;
    logic          start_stop;
    logic          clear;
    logic          mode_down;
    logic          set_mode;
    logic          inc_min;
    logic          inc_sec;
    logic          lap;
    logic [MW-1:0] min_o;
    logic [5:0]    sec_o;
    logic [7:0]    min_bcd;
    logic [7:0]    sec_bcd;
    logic [MW-1:0] lap_min;
    logic [5:0]    lap_sec;
    logic          lap_valid;
    logic          running_o;
    logic          wrap_o;
    logic          expired_o;
    logic          led_state;

    modport master (
        output power_en, start_stop, clear, mode_down, set_mode, inc_min, inc_sec, lap,
        input  min_o, sec_o, min_bcd, sec_bcd, lap_min, lap_sec, lap_valid,
               running_o, wrap_o, expired_o, led_state
    );

    modport slave (
        input  power_en, start_stop, clear, mode_down, set_mode, inc_min, inc_sec, lap,
        output min_o, sec_o, min_bcd, sec_bcd, lap_min, lap_sec, lap_valid,
               running_o, wrap_o, expired_o, led_state
    );
endinterface

// File: rtl/timer_core_param_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks.
//   clk, rst : clock and synchronous active-high reset
//   run      : advance the count
//   clr      : force the count to zero (wins over run)
//   tick     : high on the terminal count while running
// With neither run nor clr the count holds, so a paused timer keeps its
// sub-second fraction.
module tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = run && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/timer_core_param.sv
// Parametrised mm:ss timer core: count up/down, pause/resume, time set,
// lap capture and countdown expiry.
//   clk, rst : clock and synchronous active-high reset
//   bus      : timer_core_param_if.slave (controls in, time/status out)
// Time is kept in binary; the BCD outputs are a combinational view of it.
module timer_core_param
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int MIN_MAX = 59,
    parameter int MW      = 7
) (
    input logic               clk,
    input logic               rst,
    timer_core_param_if.slave bus
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;

    state_t        state_q, state_d;
    logic [MW-1:0] min_q, lap_min_q;
    logic [5:0]    sec_q, lap_sec_q;
    logic          lap_valid_q, wrap_q, exp_q, led_tog_q;
    logic          dir_q;          // count direction latched outside RUN
    logic          tick, run_tick, expire, clr_cnt, cnt_zero;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 7'd10);
        units = 4'(v % 7'd10);
        return {tens, units};
    endfunction

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  ((state_q == ST_RUN) || (state_q == ST_DONE)),
        .clr  ((state_q == ST_OFF) || (state_q == ST_IDLE) || (state_q == ST_SET)),
        .tick (tick)
    );

    assign cnt_zero = (min_q == '0) && (sec_q == '0);
    assign run_tick = (state_q == ST_RUN) && tick;
    // Countdown finishing this tick (00:00 also expires rather than borrowing).
    assign expire   = run_tick && dir_q && (min_q == '0) && (sec_q <= 6'd1);

    always_comb begin
        state_d = state_q;
        clr_cnt = 1'b0;
        if (!bus.power_en) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:   state_d = ST_IDLE;
                ST_IDLE: begin
                    if (bus.set_mode)
                        state_d = ST_SET;
                    else if (bus.start_stop && !(bus.mode_down && cnt_zero))
                        state_d = ST_RUN;
                    else if (bus.clear)
                        clr_cnt = 1'b1;
                end
                ST_RUN: begin
                    if (expire)
                        state_d = ST_DONE;
                    else if (bus.start_stop)
                        state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (bus.set_mode)
                        state_d = ST_SET;
                    else if (bus.start_stop)
                        state_d = ST_RUN;
                    else if (bus.clear) begin
                        state_d = ST_IDLE;
                        clr_cnt = 1'b1;
                    end
                end
                ST_SET: begin
                    if (!bus.set_mode)
                        state_d = ST_IDLE;
                end
                ST_DONE: begin
                    if (bus.start_stop || bus.clear) begin
                        state_d = ST_IDLE;
                        clr_cnt = bus.clear;
                    end
                end
                default:  state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_OFF;
            dir_q       <= 1'b0;
            min_q       <= '0;
            sec_q       <= '0;
            lap_min_q   <= '0;
            lap_sec_q   <= '0;
            lap_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            exp_q       <= 1'b0;
            led_tog_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= 1'b0;
            exp_q   <= 1'b0;
            if (state_q != ST_RUN)
                dir_q <= bus.mode_down;
            if (!bus.power_en) begin
                min_q       <= '0;
                sec_q       <= '0;
                lap_min_q   <= '0;
                lap_sec_q   <= '0;
                lap_valid_q <= 1'b0;
                led_tog_q   <= 1'b0;
            end else begin
                exp_q <= expire;
                if (clr_cnt) begin
                    min_q       <= '0;
                    sec_q       <= '0;
                    lap_valid_q <= 1'b0;
                end
                if (state_q == ST_SET) begin
                    if (bus.inc_sec)
                        sec_q <= (sec_q == 6'(SEC_MAX)) ? '0 : sec_q + 6'd1;
                    if (bus.inc_min)
                        min_q <= (min_q == MW'(MIN_MAX)) ? '0 : min_q + MW'(1);
                end
                if (run_tick) begin
                    if (!dir_q) begin
                        if (sec_q == 6'(SEC_MAX)) begin
                            sec_q <= '0;
                            if (min_q == MW'(MIN_MAX)) begin
                                min_q  <= '0;
                                wrap_q <= 1'b1;
                            end else begin
                                min_q <= min_q + MW'(1);
                            end
                        end else begin
                            sec_q <= sec_q + 6'd1;
                        end
                    end else if (expire) begin
                        min_q <= '0;
                        sec_q <= '0;
                    end else if (sec_q == '0) begin
                        sec_q <= 6'(SEC_MAX);
                        min_q <= min_q - MW'(1);
                    end else begin
                        sec_q <= sec_q - 6'd1;
                    end
                end
                // Captures the pre-tick value when lap lands on a tick.
                if ((state_q == ST_RUN) && bus.lap) begin
                    lap_min_q   <= min_q;
                    lap_sec_q   <= sec_q;
                    lap_valid_q <= 1'b1;
                end
                led_tog_q <= (state_q == ST_DONE) ? (led_tog_q ^ tick) : 1'b0;
            end
        end
    end

    assign bus.min_o     = min_q;
    assign bus.sec_o     = sec_q;
    assign bus.min_bcd   = to_bcd(7'(min_q));
    assign bus.sec_bcd   = to_bcd(7'(sec_q));
    assign bus.lap_min   = lap_min_q;
    assign bus.lap_sec   = lap_sec_q;
    assign bus.lap_valid = lap_valid_q;
    assign bus.running_o = (state_q == ST_RUN);
    assign bus.wrap_o    = wrap_q;
    assign bus.expired_o = exp_q;
    assign bus.led_state = (state_q == ST_RUN) || ((state_q == ST_DONE) && led_tog_q);
endmodule

// File: tb/tb_timer_core_param.sv
// Directed bench for timer_core_param with CLK_HZ=10, TICK_HZ=1 (tick every
// 10 clocks), MIN_MAX=59. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point.
module tb_timer_core_param;
    import timer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    timer_core_param_if #(.MW(7)) bus ();

    timer_core_param #(
        .CLK_HZ  (10),
        .TICK_HZ (1),
        .MIN_MAX (59),
        .MW      (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk    = 0;
    int n_err    = 0;
    int wrap_cnt = 0;
    int exp_cnt  = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance n edges, tallying the one-cycle status pulses as they appear.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.wrap_o)    wrap_cnt++;
            if (bus.expired_o) exp_cnt++;
        end
    endtask

    task automatic pulse_ss();
        bus.start_stop = 1'b1; step(1); bus.start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1; step(1); bus.clear = 1'b0;
    endtask

    task automatic pulse_lap();
        bus.lap = 1'b1; step(1); bus.lap = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.power_en   = 1'b1;
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
        bus.mode_down  = 1'b0;
        bus.set_mode   = 1'b0;
        bus.inc_min    = 1'b0;
        bus.inc_sec    = 1'b0;
        bus.lap        = 1'b0;
        step(2);
        check("init_state", dut.state_q, ST_OFF);
        rst = 1'b0;
        step(1);
        check("init_idle", dut.state_q, ST_IDLE);

        // Reset in the middle of a run.
        pulse_ss();
        step(50);
        check("pre_rst_sec", bus.sec_o, 5);
        rst = 1'b1;
        step(2);
        check("rst_state", dut.state_q, ST_OFF);
        check("rst_sec", bus.sec_o, 0);
        check("rst_min", bus.min_o, 0);
        check("rst_running", bus.running_o, 0);
        check("rst_led", bus.led_state, 0);
        check("rst_lap_valid", bus.lap_valid, 0);
        check("rst_sec_bcd", bus.sec_bcd, 0);
        rst = 1'b0;
        step(1);
        check("pwr_idle", dut.state_q, ST_IDLE);
        check("pwr_sec", bus.sec_o, 0);

        // Count up to 01:05.
        pulse_ss();
        step(650);
        check("up_min", bus.min_o, 1);
        check("up_sec", bus.sec_o, 5);
        check("up_min_bcd", bus.min_bcd, 8'h01);
        check("up_sec_bcd", bus.sec_bcd, 8'h05);
        check("up_led", bus.led_state, 1);
        check("up_running", bus.running_o, 1);

        // Preload 59:58 and run across the wrap.
        pulse_ss();
        pulse_clear();
        bus.set_mode = 1'b1;
        step(1);
        bus.inc_min = 1'b1;
        bus.inc_sec = 1'b1;
        step(58);
        bus.inc_sec = 1'b0;
        step(1);
        bus.inc_min = 1'b0;
        check("preload_min", bus.min_o, 59);
        check("preload_sec", bus.sec_o, 58);
        check("preload_min_bcd", bus.min_bcd, 8'h59);
        check("preload_sec_bcd", bus.sec_bcd, 8'h58);
        bus.set_mode = 1'b0;
        step(1);
        wrap_cnt = 0;
        pulse_ss();
        step(10);
        check("wrap_pre_sec", bus.sec_o, 59);
        check("wrap_pre_cnt", wrap_cnt, 0);
        step(10);
        check("wrap_min", bus.min_o, 0);
        check("wrap_sec", bus.sec_o, 0);
        check("wrap_pulses", wrap_cnt, 1);
        check("wrap_running", bus.running_o, 1);

        // Pause keeps the sub-second fraction.
        pulse_ss();
        pulse_clear();
        pulse_ss();
        step(34);
        pulse_ss();
        check("pause_sec", bus.sec_o, 3);
        check("pause_running", bus.running_o, 0);
        step(100);
        check("pause_hold_sec", bus.sec_o, 3);
        pulse_ss();
        step(4);
        check("resume_early", bus.sec_o, 3);
        step(1);
        check("resume_tick", bus.sec_o, 4);

        // Lap on a tick edge, clear ignored in RUN, clear after pause.
        step(39);
        check("lap_pre_sec", bus.sec_o, 7);
        pulse_lap();
        check("lap_sec", bus.lap_sec, 7);
        check("lap_min", bus.lap_min, 0);
        check("lap_live_sec", bus.sec_o, 8);
        check("lap_valid", bus.lap_valid, 1);
        pulse_clear();
        check("clr_run_sec", bus.sec_o, 8);
        check("clr_run_lapv", bus.lap_valid, 1);
        pulse_ss();
        pulse_clear();
        check("clr_pause_sec", bus.sec_o, 0);
        check("clr_pause_lapv", bus.lap_valid, 0);
        check("clr_pause_state", dut.state_q, ST_IDLE);

        // Time set and countdown to expiry.
        bus.set_mode = 1'b1;
        step(1);
        bus.inc_min = 1'b1;
        step(2);
        bus.inc_min = 1'b0;
        bus.inc_sec = 1'b1;
        step(3);
        check("set_min", bus.min_o, 2);
        check("set_sec", bus.sec_o, 3);
        step(57);
        check("set_wrap_sec", bus.sec_o, 0);
        check("set_wrap_min", bus.min_o, 2);
        bus.inc_sec   = 1'b0;
        bus.set_mode  = 1'b0;
        bus.mode_down = 1'b1;
        step(1);
        exp_cnt = 0;
        pulse_ss();
        step(600);
        check("down_mid_min", bus.min_o, 1);
        check("down_mid_sec", bus.sec_o, 0);
        check("down_mid_bcd", bus.min_bcd, 8'h01);
        step(600);
        check("down_min", bus.min_o, 0);
        check("down_sec", bus.sec_o, 0);
        check("down_expired", exp_cnt, 1);
        check("down_state", dut.state_q, ST_DONE);
        check("done_led0", bus.led_state, 0);
        step(10);
        check("done_led1", bus.led_state, 1);
        step(10);
        check("done_led2", bus.led_state, 0);
        check("done_expired", exp_cnt, 1);
        check("done_sec", bus.sec_o, 0);
        pulse_clear();
        check("done_exit", dut.state_q, ST_IDLE);

        // Countdown start at 00:00 is refused; power-off mid run.
        pulse_ss();
        check("down_zero_state", dut.state_q, ST_IDLE);
        check("down_zero_run", bus.running_o, 0);
        bus.mode_down = 1'b0;
        pulse_ss();
        step(30);
        check("off_pre_sec", bus.sec_o, 3);
        pulse_lap();
        check("off_pre_lap", bus.lap_sec, 3);
        bus.power_en = 1'b0;
        step(1);
        check("off_state", dut.state_q, ST_OFF);
        check("off_sec", bus.sec_o, 0);
        check("off_lap_sec", bus.lap_sec, 0);
        check("off_lapv", bus.lap_valid, 0);
        check("off_running", bus.running_o, 0);
        bus.power_en = 1'b1;
        step(1);
        check("on_idle", dut.state_q, ST_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
